lsu_mem_port: RTL and testbench

- Load/store initiator that drives the data-side port of the unified instruction/data memory on behalf of the execute/memory pipeline stage.
- Accepts one RV32I load or store request at a time and issues word-aligned accesses on the memory data port.
- Extracts and sign- or zero-extends byte and halfword loads.
- Implements byte and halfword stores as read-modify-write, because the memory only writes whole words.

---
 rtl/lsu_mem_port.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Data-side load/store initiator for the unified memory.
// Sub-word stores are done as read-modify-write because the memory only writes whole words.
module lsu_mem_port #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_CAP  = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                wen_q, wen_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_LEN-1:0] resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic                bad_funct3;
    logic                misaligned;
    logic [7:0]          rd_lane [4];
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [WORD_LEN-1:0] load_ext;
    logic [WORD_LEN-1:0] merged;

    always_comb begin
        bad_funct3 = req_wen ? (req_funct3 > 3'b010)
                             : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0])
                  || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    end

    // Per byte lane: split the read word, and build the merged store word
    // (SB writes wdata[7:0] into one lane, SH writes wdata[15:0] into a lane pair).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            logic [7:0] new_byte;
            assign rd_lane[gi] = mem_rdata[8*gi +: 8];
            assign lane_hit    = (funct3_q[1:0] == 2'b00) ? (addr_lo_q == 2'(gi))
                                                          : (addr_lo_q[1] == 1'(gi / 2));
            assign new_byte    = funct3_q[0] ? wdata_q[8*(gi % 2) +: 8] : wdata_q[7:0];
            assign merged[8*gi +: 8] = lane_hit ? new_byte : rd_lane[gi];
        end
    endgenerate

    always_comb begin
        byte_sel = rd_lane[addr_lo_q];
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{(WORD_LEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(WORD_LEN-16){half_sel[15]}}, half_sel};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {{(WORD_LEN-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(WORD_LEN-16){1'b0}}, half_sel};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        funct3_d     = funct3_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_lo_d = req_addr[1:0];
                    funct3_d  = req_funct3;
                    wen_d     = req_wen;
                    wdata_d   = req_wdata[15:0];
                    if (bad_funct3 || misaligned) begin
                        // Rejected requests never touch the memory bus.
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[WORD_LEN-1:2], 2'b00};
                        if (req_wen && req_funct3 == 3'b010) begin
                            state_d     = S_WR;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d = S_RD_ADDR;
                        end
                    end
                end
            end
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP: begin
                if (wen_q) begin
                    mem_wdata_d = merged;
                    state_d     = S_WR;
                end else begin
                    resp_rdata_d = load_ext;
                    state_d      = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            funct3_q     <= funct3_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Write enable is qualified by rst so an in-flight store is dropped cleanly.
    assign mem_wen    = (state_q == S_WR) && !rst;
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-level memory/timing model checked against the DUT every cycle,
// plus literal expectations for each directed request.
module tb_lsu_mem_port;
    localparam int NCYC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_port #(.WORD_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory seen by the DUT: 1-cycle read latency, write at the enabled edge.
    logic [31:0] mem [256];
    logic        preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'h8899AABB;
            mem[5] <= 32'h11223344;
            mem[8] <= 32'h00000000;
        end else if (mem_wen) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[9:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: reference memory and per-cycle expected outputs.
    logic [31:0] ref_mem [256];
    bit          exp_ready [NCYC];
    bit          exp_resp  [NCYC];
    bit          exp_err   [NCYC];
    bit          exp_wen   [NCYC];
    logic [31:0] exp_rdata [NCYC];
    logic [31:0] exp_waddr [NCYC];
    logic [31:0] exp_wdata [NCYC];

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    int          n_resp = 0;
    int          n_wr = 0;
    int          last_resp_cyc = -1;
    int          last_wr_cyc = -1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp_v);
    endtask

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] w,
                                             input logic [1:0] a);
        logic [31:0] s;
        s = w >> (8 * a);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return w;
            3'b100:  return s & 32'h0000_00FF;
            3'b101:  return s & 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready[cyc]});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp[cyc]});
            chk("resp_rdata", resp_rdata, exp_rdata[cyc]);
            chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err[cyc]});
            chk("mem_wen", {31'b0, mem_wen}, {31'b0, exp_wen[cyc]});
            if (exp_wen[cyc]) begin
                chk("mem_addr", mem_addr, exp_waddr[cyc]);
                chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
            end
            if (resp_valid) begin
                n_resp++;
                last_resp_cyc = cyc;
                last_rdata = resp_rdata;
                last_err = resp_err;
            end
            if (mem_wen) begin
                n_wr++;
                last_wr_cyc = cyc;
                last_wdata = mem_wdata;
            end
        end
    end

    // Issue one request at the current negedge (cycle T). abort_k>0 asserts rst during T+abort_k.
    // lit_* are hand-computed: response data/error/latency and write offset/data (woff 0 = no write).
    task automatic do_req(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold, input int abort_k,
                          input logic [31:0] lit_rdata, input bit lit_err, input int lit_lat,
                          input int lit_woff, input logic [31:0] lit_wdata);
        int T, lat, woff, sh, wr0, rs0;
        bit legal, err;
        logic [31:0] w, r, mask, neww;
        T = cyc;
        wr0 = n_wr;
        rs0 = n_resp;
        case (f3)
            3'b000, 3'b100: legal = !wen || f3 == 3'b000;
            3'b001, 3'b101: legal = (!wen || f3 == 3'b001) && addr[0] == 1'b0;
            3'b010:         legal = addr[1:0] == 2'b00;
            default:        legal = 1'b0;
        endcase
        sh = 8 * int'(addr[1:0]);
        w = ref_mem[addr[9:2]];
        r = 32'h0; err = 1'b0; woff = 0; neww = 32'h0;
        if (!legal) begin
            lat = 1; err = 1'b1;
        end else if (!wen) begin
            lat = 3; r = load_val(f3, w, addr[1:0]);
        end else if (f3 == 3'b010) begin
            lat = 2; woff = 1; neww = wdata;
        end else begin
            lat = 4; woff = 3;
            mask = ((f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
            neww = (w & ~mask) | ((wdata << sh) & mask);
        end
        for (int k = 1; k <= lat; k++)
            if (abort_k == 0 || k <= abort_k) exp_ready[T+k] = 1'b0;
        if (abort_k == 0 || lat < abort_k) begin
            exp_resp[T+lat] = 1'b1; exp_rdata[T+lat] = r; exp_err[T+lat] = err;
        end
        if (woff != 0 && (abort_k == 0 || woff < abort_k)) begin
            exp_wen[T+woff] = 1'b1;
            exp_waddr[T+woff] = {addr[31:2], 2'b00};
            exp_wdata[T+woff] = neww;
            ref_mem[addr[9:2]] = neww;
        end

        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        if (abort_k != 0) begin
            repeat (abort_k - 1) @(negedge clk);
            req_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_no_resp", n_resp, rs0);
            chk("abort_no_write", n_wr, wr0);
        end else begin
            repeat (lat - 1) @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            $display("req wen=%0d f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                     wen, f3, addr, wdata, last_rdata, last_err, last_resp_cyc - T);
            chk("pin_latency", last_resp_cyc - T, lit_lat);
            chk("pin_rdata", last_rdata, lit_rdata);
            chk("pin_err", {31'b0, last_err}, {31'b0, lit_err});
            chk("pin_nwrites", n_wr - wr0, (lit_woff != 0) ? 1 : 0);
            if (lit_woff != 0) begin
                chk("pin_write_offset", last_wr_cyc - T, lit_woff);
                chk("pin_wdata", last_wdata, lit_wdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_ready[i] = 1'b1; exp_resp[i] = 1'b0; exp_err[i] = 1'b0; exp_wen[i] = 1'b0;
            exp_rdata[i] = '0; exp_waddr[i] = '0; exp_wdata[i] = '0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[4] = 32'h8899AABB;
        ref_mem[5] = 32'h11223344;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        preload = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        //     wen  f3      addr          wdata         hold abort rdata        err lat woff wdata
        do_req(1'b0, 3'b000, 32'h11, 32'h0,          1'b0, 0, 32'hFFFFFFAA, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0,          1'b0, 0, 32'h00000088, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0,          1'b0, 0, 32'hFFFF8899, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b101, 32'h10, 32'h0,          1'b0, 0, 32'h0000AABB, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0,          1'b0, 0, 32'h8899AABB, 1'b0, 3, 0, 32'h0);
        do_req(1'b1, 3'b000, 32'h11, 32'h12345655,   1'b1, 0, 32'h0,        1'b0, 4, 3, 32'h889955BB);
        do_req(1'b0, 3'b010, 32'h10, 32'h0,          1'b0, 0, 32'h889955BB, 1'b0, 3, 0, 32'h0);
        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF,   1'b1, 0, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h20, 32'h0,          1'b0, 0, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0);
        do_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF,   1'b0, 0, 32'h0,        1'b1, 1, 0, 32'h0);
        do_req(1'b0, 3'b010, 32'h12, 32'h0,          1'b0, 0, 32'h0,        1'b1, 1, 0, 32'h0);
        do_req(1'b0, 3'b011, 32'h14, 32'h0,          1'b0, 0, 32'h0,        1'b1, 1, 0, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'h000000FF,   1'b0, 0, 32'h0,        1'b1, 1, 0, 32'h0);
        do_req(1'b1, 3'b001, 32'h14, 32'h00005555,   1'b0, 2, 32'h0,        1'b0, 0, 0, 32'h0);
        $display("abort: SH 0x14 reset in RD_CAP, word 0x14 = %h", mem[5]);
        chk("abort_word_kept", mem[5], 32'h11223344);
        do_req(1'b0, 3'b010, 32'h14, 32'h0,          1'b0, 0, 32'h11223344, 1'b0, 3, 0, 32'h0);
        do_req(1'b1, 3'b001, 32'h16, 32'h0000CAFE,   1'b0, 0, 32'h0,        1'b0, 4, 3, 32'hCAFE3344);
        do_req(1'b0, 3'b101, 32'h16, 32'h0,          1'b0, 0, 32'h0000CAFE, 1'b0, 3, 0, 32'h0);
        do_req(1'b0, 3'b000, 32'h17, 32'h0,          1'b0, 0, 32'hFFFFFFCA, 1'b0, 3, 0, 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
